// File: rtl/decode_buffer.sv
// IF->ID decoupling queue of {pc, instr, is_ds}; delay-slot tags are computed at enqueue time.
// Optional zero-latency empty-queue bypass when DBUF_BYPASS_EN is defined.
module decode_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_is_ds,
    input  logic          redirect,
    input  logic          flush,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] ds_mem;

    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic          last_br;
    logic          ds_pend;

    logic       full;
    logic       empty;
    logic       one;
    logic [5:0] op;
    logic [5:0] func;
    logic       is_br;
    logic       ds_tag;
    logic       byp;
    logic       enq;
    logic       deq;
    logic       redir;
    logic       mem_we;
    logic       mem_ds;

    // Status, predecode, head presentation and write decision
    always_comb begin
        full   = (count == CW'(DEPTH));
        empty  = (count == '0);
        one    = (count == CW'(1));
        op     = in_instr[31:26];
        func   = in_instr[5:0];
        is_br  = ((op != 6'd0) && (op <= 6'd7)) ||
                 ((op == 6'd0) && ((func == 6'b001000) || (func == 6'b001001)));
        ds_tag = last_br | ds_pend;
`ifdef DBUF_BYPASS_EN
        byp    = empty & in_valid & out_ready & ~flush;
`else
        byp    = 1'b0;
`endif
        in_ready  = ~full;
        out_valid = ~empty | byp;
        out_pc    = 32'd0;
        out_instr = 32'd0;
        out_is_ds = 1'b0;
        if (byp) begin
            out_pc    = in_pc;
            out_instr = in_instr;
            out_is_ds = ds_tag;
        end else if (!empty) begin
            out_pc    = pc_mem[rd];
            out_instr = instr_mem[rd];
            out_is_ds = ds_mem[rd];
        end
        deq   = out_valid & out_ready;
        enq   = in_valid & ~full;
        redir = redirect & deq;
        // On a redirect only a sole-remaining-entry enqueue survives, forced to be the slot
        mem_we = 1'b0;
        mem_ds = ds_tag;
        if (!flush) begin
            if (redir) begin
                mem_we = one & enq;
                mem_ds = 1'b1;
            end else begin
                mem_we = enq & ~byp;
            end
        end
    end

    // Entry storage; contents are masked at the output while invalid
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pc_mem[wr]    <= in_pc;
            instr_mem[wr] <= in_instr;
            ds_mem[wr]    <= mem_ds;
        end
    end

    // Pointers, occupancy and delay-slot tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd      <= '0;
            wr      <= '0;
            count   <= '0;
            last_br <= 1'b0;
            ds_pend <= 1'b0;
        end else if (flush) begin
            rd      <= '0;
            wr      <= '0;
            count   <= '0;
            last_br <= 1'b0;
            ds_pend <= 1'b0;
        end else if (redir) begin
            last_br <= 1'b0;
            ds_pend <= 1'b0;
            if (!empty && !one) begin
                rd    <= rd + AW'(1);
                wr    <= rd + AW'(2);
                count <= CW'(1);
            end else if (byp) begin
                ds_pend <= 1'b1;
                last_br <= is_br;
            end else if (enq) begin
                rd      <= rd + AW'(1);
                wr      <= wr + AW'(1);
                last_br <= is_br;
            end else begin
                rd      <= rd + AW'(1);
                count   <= '0;
                ds_pend <= 1'b1;
            end
        end else if (byp) begin
            last_br <= is_br;
            ds_pend <= 1'b0;
        end else begin
            if (enq) begin
                wr      <= wr + AW'(1);
                last_br <= is_br;
                ds_pend <= 1'b0;
            end
            if (deq) begin
                rd <= rd + AW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed self-checking bench for decode_buffer (DEPTH=4); honours DBUF_BYPASS_EN if defined.
module tb_decode_buffer;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = 32'h1022_0003;
    localparam logic [31:0] ADDU = 32'h0022_1821;
    localparam logic [31:0] JR   = 32'h03E0_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_is_ds;
    logic        redirect;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    decode_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_is_ds(out_is_ds), .redirect(redirect), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Check head pc/ds then dequeue it
    task automatic expect_pop(input string tag, input logic [31:0] pc, input logic ds);
        #1;
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_ds"}, 32'(out_is_ds), 32'(ds));
        pop();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; redirect = 1'b0; flush = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_is_ds", 32'(out_is_ds), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Fill to full, latency one cycle
        push(32'hBFC0_0000, NOP);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_pc", out_pc, 32'hBFC0_0000);
        for (int i = 1; i < 4; i++) push(32'hBFC0_0000 + 32'(4 * i), NOP);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        // Full with same-cycle dequeue: enqueue refused
        in_valid = 1'b1; in_pc = 32'hDEAD_0000; out_ready = 1'b1;
        #1;
        check("full_deq_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("full_deq_count", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) expect_pop("drain", 32'hBFC0_0000 + 32'(4 * i), 1'b0);
        #1;
        check("drain_count", 32'(count), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);

        // Second pass streaming, wraps pointers
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * k); in_instr = NOP; out_ready = 1'b1;
            #1;
`ifdef DBUF_BYPASS_EN
            check("stream_pc", out_pc, 32'h1000 + 32'(4 * k));
            check("stream_count", 32'(count), 32'd0);
`else
            if (k > 0) begin
                check("stream_pc", out_pc, 32'h1000 + 32'(4 * (k - 1)));
                check("stream_count", 32'(count), 32'd1);
            end
`endif
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
`ifndef DBUF_BYPASS_EN
        expect_pop("stream_last", 32'h1014, 1'b0);
`endif

        // Delay-slot tagging
        push(32'h100, BEQ); push(32'h104, ADDU); push(32'h108, ADDU);
        expect_pop("tag0", 32'h100, 1'b0);
        expect_pop("tag1", 32'h104, 1'b1);
        expect_pop("tag2", 32'h108, 1'b0);

        // Redirect with buffered slot
        push(32'h100, BEQ); push(32'h104, ADDU); push(32'h108, ADDU); push(32'h10C, ADDU);
        out_ready = 1'b1; redirect = 1'b1;
        #1;
        check("redir_head", out_pc, 32'h100);
        tick();
        out_ready = 1'b0; redirect = 1'b0;
        #1;
        check("redir_count", 32'(count), 32'd1);
        expect_pop("redir_slot", 32'h104, 1'b1);
        #1;
        check("redir_empty", 32'(out_valid), 32'd0);

        // Redirect with empty remainder
        push(32'h200, JR);
        out_ready = 1'b1; redirect = 1'b1;
        tick();
        out_ready = 1'b0; redirect = 1'b0;
        #1;
        check("pend_count", 32'(count), 32'd0);
        push(32'h204, NOP); push(32'h400, NOP);
        expect_pop("pend_slot", 32'h204, 1'b1);
        expect_pop("pend_target", 32'h400, 1'b0);

        // Redirect of sole entry with same-cycle enqueue
        push(32'h300, JR);
        out_ready = 1'b1; redirect = 1'b1;
        in_valid = 1'b1; in_pc = 32'h304; in_instr = NOP;
        tick();
        out_ready = 1'b0; redirect = 1'b0; in_valid = 1'b0;
        #1;
        check("redir1_count", 32'(count), 32'd1);
        expect_pop("redir1_slot", 32'h304, 1'b1);

        // Flush with same-cycle enqueue
        push(32'h500, NOP); push(32'h504, NOP); push(32'h508, BEQ);
        #1;
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h50C; in_instr = NOP;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        push(32'h600, NOP);
        expect_pop("post_flush", 32'h600, 1'b0);

        // Asynchronous reset mid-cycle
        push(32'h900, NOP); push(32'h904, BEQ);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b1;
        tick();
        push(32'h908, NOP);
        expect_pop("post_rst", 32'h908, 1'b0);

        // Empty-queue enqueue with out_ready high
        in_valid = 1'b1; in_pc = 32'h800; in_instr = NOP; out_ready = 1'b1;
        #1;
`ifdef DBUF_BYPASS_EN
        check("byp_valid", 32'(out_valid), 32'd1);
        check("byp_pc", out_pc, 32'h800);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("byp_count", 32'(count), 32'd0);
`else
        check("nobyp_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("nobyp_valid_next", 32'(out_valid), 32'd1);
        check("nobyp_pc_next", out_pc, 32'h800);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised instruction decoupling queue between the IF stage and the ID stage. It holds fetched {PC, instruction} pairs and presents them to decode through a valid/ready handshake. It also computes the branch-delay-slot flag for each entry at enqueue time, so the tag no longer depends on PC-repeat heuristics. On a taken branch it keeps only the delay slot, and on an exception it discards everything.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of 2, ≥2.
- `AW`, default 2: log2(DEPTH); pointer width.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: IF presents an instruction.
- `in_ready` output 1: buffer can accept; equals !full.
- `in_pc` input 32: PC of the fetched instruction.
- `in_instr` input 32: fetched instruction word.
- `out_valid` output 1: head entry valid for ID.
- `out_ready` input 1: ID accepts head (`out_fire` = `out_valid` & `out_ready`).
- `out_pc` output 32: head PC.
- `out_instr` output 32: head instruction.
- `out_is_ds` output 1: head is a branch delay slot.
- `redirect` input 1: ID resolved the instruction dequeued this cycle as a taken branch/jump; legal only with `out_fire`.
- `flush` input 1: exception/ERET flush; discards all state.
- `count` output AW+1: current occupancy.

## Operation
- Storage: circular array of {pc, instr, is_ds}, read pointer `rd`, write pointer `wr`, occupancy `count`; `full` = (count==DEPTH), `empty` = (count==0).
- Enqueue (`in_valid` & `in_ready`): write {in_pc, in_instr, ds_tag} at `wr`; `wr` increments mod DEPTH.
- Predecode of `in_instr` sets `last_br` on every enqueue. An instruction is a branch when:
  - op ∈ {000001, 000010, 000011, 000100, 000101, 000110, 000111}, or
  - op==000000 and func ∈ {001000, 001001}.
- ds_tag = `last_br` | `ds_pend`.
- Dequeue (`out_fire`): `rd` increments mod DEPTH. Outputs are always the entry at `rd` (registered array read, no extra pipeline).
- `in_ready` does not depend on `out_ready`. When full, a same-cycle dequeue does not allow an enqueue.
- Redirect (with `out_fire`): every entry beyond the dequeued branch is discarded except the first, which is the delay slot.
  - count−1 ≥ 1: keep the entry at rd+1 (already tagged ds); count becomes 1; `wr` = rd+2; any same-cycle enqueue is dropped.
  - count−1 == 0 and enqueue this cycle: the incoming entry is kept and tagged ds; count becomes 1.
  - count−1 == 0 and no enqueue: set `ds_pend`. The next enqueued entry is tagged ds and clears `ds_pend`. Later enqueues are the branch target.
  - `last_br` is cleared on redirect, except when it is set by a same-cycle enqueued entry.
- Flush: `rd`, `wr`, `count`, `last_br` and `ds_pend` are cleared; a same-cycle enqueue is dropped.
- Priority: `rst` > `flush` > `redirect` > normal enqueue/dequeue.
- `redirect` without `out_fire` is ignored.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_is_ds`=0.
  - `count`=0; pointers, `last_br` and `ds_pend` are 0.
- Latency: an instruction enqueued in cycle N is visible on `out_*` in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle when not full and not empty.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first enqueue after reset release is tagged not-ds.
- `out_*` are stable while `out_valid` & !`out_ready`.
- Pointer wrap: DEPTH−1 → 0 with no bubble.

## Configuration
- `DBUF_BYPASS_EN` defined: when `empty` & `in_valid` & `out_ready` & !`flush`, the input is passed combinationally to `out_*` (`out_valid`=1) and not written to the array. This gives zero latency. The ds_tag, `last_br` and `ds_pend` updates are identical to the enqueue path.
- `DBUF_BYPASS_EN` undefined: there is no bypass path; enqueue-to-output latency is always one cycle.

## Test plan
- Fill and drain, DEPTH=4: enqueue PCs 0xBFC00000–0xBFC0000C with `out_ready`=0. Required: `in_ready`=0 and `count`=4. Then drain: PCs emerge in order, `in_ready` returns to 1, and wrap-around is exercised across two passes.
- Delay-slot tagging: enqueue beq (0x10220003) @0x100, then addu @0x104, then addu @0x108. Required: `out_is_ds` = 0, 1, 0.
- Redirect with a buffered slot: queue holds beq@0x100, ds@0x104, x@0x108, y@0x10C; dequeue beq with `redirect`=1. Required: `count`=1; the next output is 0x104 with `out_is_ds`=1; 0x108 and 0x10C never appear.
- Redirect with an empty remainder: queue holds jr@0x200 only; dequeue with `redirect`. Then enqueue 0x204, then target 0x400. Required: 0x204 is tagged ds; 0x400 is tagged not-ds.
- Flush during a same-cycle enqueue: `flush`=1 with `in_valid`=1 and `count`=3. Required: next cycle `count`=0 and `out_valid`=0; a later enqueue is tagged not-ds.
- Asynchronous reset: pull `rst` low mid-cycle with `count`=2. Required: `out_valid`=0 and `count`=0 before the next clock edge. With `DBUF_BYPASS_EN` defined, `in_valid` into an empty buffer with `out_ready`=1 yields `out_valid`=1 in the same cycle.
